// File: rtl/instr_fetch_stage.sv
// Fetch stage with IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, and latches the fetched
// word together with PC+4 for decode. Supports stall, flush, redirect and halt.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               PCSrc,
  input  logic [31:0]        BranchTarget,
  input  logic               Halt,
  input  logic [31:0]        IMemData,
  output logic [31:0]        IMemAddr,
  output logic [31:0]        PC,
  output logic [31:0]        Instruction,
  output logic [31:0]        PCPlus4,
  output logic               ValidID,
  output logic               Halted,
  output logic [COUNT_W-1:0] FetchCount
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  // Low PC bits are forced to zero so a misaligned RESET_PC can never leak out.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         pcp4_q, pcp4_d;
  logic                valid_q, valid_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic [31:0]         pc_plus4;
  logic [31:0]         redirect_pc;
  logic                unused_bt_low;

  // Redirect target low bits are discarded; kept only to mark them as consumed.
  assign unused_bt_low = ^BranchTarget[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {BranchTarget[31:2], 2'b00};

  // State and pipeline registers, asynchronously cleared by the active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= NOP_WORD;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state and next-register logic; RUN actions are prioritised halt,
  // redirect, flush, stall, then a normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;

    unique case (state_q)
      BOOT: begin
        // One idle cycle after reset release: nothing fetched, PC held.
        state_d = RUN;
      end

      RUN: begin
        if (Halt && valid_q) begin
          state_d = HALT;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (PCSrc) begin
          // The word fetched this cycle is from the wrong path; drop it.
          pc_d    = redirect_pc;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (Flush) begin
          pc_d    = pc_plus4;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (Stall) begin
          // Hold everything.
        end else begin
          pc_d    = pc_plus4;
          instr_d = IMemData;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
          count_d = count_q + COUNT_W'(1);
        end
      end

      HALT: begin
        // Frozen until reset; ID only ever sees a bubble.
        valid_d = 1'b0;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign IMemAddr    = pc_q;
  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign PCPlus4     = pcp4_q;
  assign ValidID     = valid_q;
  assign Halted      = (state_q == HALT);
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage (RESET_PC=0x100, COUNT_W=4).
module tb_instr_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        Halt;
  logic [31:0] IMemData;
  logic [31:0] IMemAddr;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        ValidID;
  logic        Halted;
  logic [3:0]  FetchCount;

  int unsigned errors = 0;
  int unsigned checks = 0;

  instr_fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .COUNT_W  (4)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .Flush        (Flush),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .Halt         (Halt),
    .IMemData     (IMemData),
    .IMemAddr     (IMemAddr),
    .PC           (PC),
    .Instruction  (Instruction),
    .PCPlus4      (PCPlus4),
    .ValidID      (ValidID),
    .Halted       (Halted),
    .FetchCount   (FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory: every address returns a distinct, address-derived word.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign IMemData = mem(IMemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic h, input logic [3:0] c);
    chk({tag, ".pc"},    PC,          pc);
    chk({tag, ".addr"},  IMemAddr,    pc);
    chk({tag, ".instr"}, Instruction, ins);
    chk({tag, ".pcp4"},  PCPlus4,     p4);
    chk({tag, ".valid"}, {31'b0, ValidID}, {31'b0, v});
    chk({tag, ".halted"},{31'b0, Halted},  {31'b0, h});
    chk({tag, ".count"}, {28'b0, FetchCount}, {28'b0, c});
  endtask

  initial begin
    Rst = 1'b0; Stall = 1'b0; Flush = 1'b0; PCSrc = 1'b0;
    BranchTarget = '0; Halt = 1'b0;

    // T1: reset and boot
    #12;
    chk_all("reset", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    Rst = 1'b1;
    step();
    chk_all("boot_edge1", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    step();
    chk_all("boot_edge2", 32'h104, mem(32'h100), 32'h104, 1'b1, 1'b0, 4'd1);
    step();
    chk_all("fetch3", 32'h108, mem(32'h104), 32'h108, 1'b1, 1'b0, 4'd2);

    // T2: stall for three edges at PC=0x108
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'h108, mem(32'h104), 32'h108, 1'b1, 1'b0, 4'd2);
    end
    Stall = 1'b0;
    step();
    chk_all("stall_resume", 32'h10C, mem(32'h108), 32'h10C, 1'b1, 1'b0, 4'd3);

    // Flush alone: bubble, PC advances, PCPlus4 kept
    Flush = 1'b1;
    step();
    chk_all("flush", 32'h110, 32'h0, 32'h10C, 1'b0, 1'b0, 4'd3);
    Flush = 1'b0;

    // T3: redirect wins over stall and flush; target low bits dropped
    PCSrc = 1'b1; Stall = 1'b1; Flush = 1'b1; BranchTarget = 32'h0000_2003;
    step();
    chk_all("redirect", 32'h2000, 32'h0, 32'h10C, 1'b0, 1'b0, 4'd3);
    PCSrc = 1'b0; Stall = 1'b0; Flush = 1'b0;
    step();
    chk_all("redirect_fetch", 32'h2004, mem(32'h2000), 32'h2004, 1'b1, 1'b0, 4'd4);

    // Halt with bubble in ID is ignored
    Flush = 1'b1;
    step();
    chk_all("flush2", 32'h2008, 32'h0, 32'h2004, 1'b0, 1'b0, 4'd4);
    Flush = 1'b0; Halt = 1'b1;
    step();
    chk_all("halt_on_bubble", 32'h200C, mem(32'h2008), 32'h200C, 1'b1, 1'b0, 4'd5);
    Halt = 1'b0;

    // T4: PC wrap and FetchCount wrap
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFE;
    step();
    chk_all("redirect_top", 32'hFFFF_FFFC, 32'h0, 32'h200C, 1'b0, 1'b0, 4'd5);
    PCSrc = 1'b0;
    step();
    chk_all("pc_wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0, 4'd6);
    for (int i = 0; i < 9; i++) step();
    chk_all("count15", 32'h24, mem(32'h20), 32'h24, 1'b1, 1'b0, 4'd15);
    step();
    chk_all("count_wrap", 32'h28, mem(32'h24), 32'h28, 1'b1, 1'b0, 4'd0);

    // T5: halt with valid instruction in ID; all inputs then ignored
    Halt = 1'b1;
    step();
    chk_all("halt", 32'h28, 32'h0, 32'h28, 1'b0, 1'b1, 4'd0);
    Halt = 1'b0; BranchTarget = 32'h0000_3000;
    for (int i = 0; i < 10; i++) begin
      PCSrc = i[0];
      Stall = i[1];
      Flush = ~i[0];
      step();
      chk_all("halt_frozen", 32'h28, 32'h0, 32'h28, 1'b0, 1'b1, 4'd0);
    end
    PCSrc = 1'b0; Stall = 1'b0; Flush = 1'b0;

    // Reset clears HALT
    #2 Rst = 1'b0;
    #1;
    chk_all("reset_from_halt", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    Rst = 1'b1;
    step();
    chk_all("reboot_edge1", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    step();
    chk_all("reboot_edge2", 32'h104, mem(32'h100), 32'h104, 1'b1, 1'b0, 4'd1);

    // T6: async reset mid-run at PC=0x140
    PCSrc = 1'b1; BranchTarget = 32'h0000_013C;
    step();
    chk_all("redirect_13c", 32'h13C, 32'h0, 32'h104, 1'b0, 1'b0, 4'd1);
    PCSrc = 1'b0;
    step();
    chk_all("at_140", 32'h140, mem(32'h13C), 32'h140, 1'b1, 1'b0, 4'd2);
    #2 Rst = 1'b0;
    #1;
    chk_all("async_reset", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    step();
    chk_all("reset_held", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    Rst = 1'b1;
    step();
    chk_all("rerun_edge1", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    step();
    chk_all("rerun_edge2", 32'h104, mem(32'h100), 32'h104, 1'b1, 1'b0, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
